display_upc_decoder: RTL and testbench

Inverse of the store display path: accepts a serial stream of six active-low 7-segment digit patterns, DU0 first, and recovers the 3-bit UPC of the store item the frame spells. It matches each incoming digit against the item table on the fly and reports the matching UPC, or an error if no item matches. It sits between a display-capture or HEX-scan front end and the register/checkout logic, closing the loop on what is actually shown on HEX0–HEX5.

---
 rtl/display_pkg.sv | 52 +++++
 rtl/seg_pattern_match.sv | 25 ++
 rtl/display_upc_decoder.sv | 104 ++++++++++
 tb/tb_display_upc_decoder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the display UPC decoder: segment glyphs, item UPCs,
// the per-item digit pattern table and the frame-collection state encoding.
// Ports: none (package).
package display_pkg;

  // Active-low 7-segment glyphs, same bit order as the HEX outputs.
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_N     = 7'b1001000;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int NUM_ITEMS = 6;
  localparam int FRAME_LEN = 6;

  // Item UPCs. 010 and 111 are unassigned.
  localparam logic [2:0] UPC_COFFEE = 3'b000;
  localparam logic [2:0] UPC_HUBCAP = 3'b001;
  localparam logic [2:0] UPC_CANDLE = 3'b011;
  localparam logic [2:0] UPC_POPCD  = 3'b100;
  localparam logic [2:0] UPC_PHONE  = 3'b101;
  localparam logic [2:0] UPC_BEDPAN = 3'b110;

  // Row i of the pattern table belongs to the item whose UPC is ITEM_UPC[i].
  localparam logic [2:0] ITEM_UPC [NUM_ITEMS] = '{
    UPC_COFFEE, UPC_HUBCAP, UPC_CANDLE, UPC_POPCD, UPC_PHONE, UPC_BEDPAN
  };

  // Digit patterns DU0..DU5 per item.
  localparam logic [6:0] ITEM_PAT [NUM_ITEMS][FRAME_LEN] = '{
    '{SEG_C, SEG_O, SEG_F, SEG_F,     SEG_E, SEG_E    },  // COFFEE
    '{SEG_H, SEG_U, SEG_B, SEG_C,     SEG_A, SEG_P    },  // HUbCAP
    '{SEG_C, SEG_A, SEG_N, SEG_D,     SEG_L, SEG_E    },  // CANdLE
    '{SEG_P, SEG_O, SEG_P, SEG_BLANK, SEG_C, SEG_D    },  // POP Cd
    '{SEG_P, SEG_H, SEG_O, SEG_N,     SEG_E, SEG_BLANK},  // PHONE
    '{SEG_B, SEG_E, SEG_D, SEG_P,     SEG_A, SEG_N    }   // bEdPAN
  };

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/seg_pattern_match.sv
// Compares one incoming digit against column idx of the item table.
// Latency: combinational. Backpressure: none, purely a function of its inputs.
// Ports: seg_in (digit pattern), idx (digit position 0..5),
//        match (bit i set when item i shows seg_in at position idx).
module seg_pattern_match
  import display_pkg::*;
(
  input  logic [6:0] seg_in,
  input  logic [2:0] idx,
  output logic [5:0] match
);

  // Constant-index selection keeps positions 6/7 from ever matching.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      for (int j = 0; j < FRAME_LEN; j++) begin
        if (idx == 3'(j)) begin
          match[i] = (seg_in == ITEM_PAT[i][j]);
        end
      end
    end
  end

endmodule

// File: rtl/display_upc_decoder.sv
// Recovers the item UPC from a serial stream of six active-low digit patterns.
// Latency: result pulse one cycle after the 6th digit is accepted.
// Backpressure: none; accepts a digit every cycle, gaps of any length allowed.
// Ports: clk, reset (sync, active-high), seg_in/seg_valid/seg_sof (digit stream),
//        frame_active, upc_out, upc_valid, upc_err (decode status and result).
module display_upc_decoder
  import display_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  input  logic       seg_sof,
  output logic       frame_active,
  output logic [2:0] upc_out,
  output logic       upc_valid,
  output logic       upc_err
);

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [5:0] mask, mask_nxt;
  logic [2:0] upc_nxt;
  logic       valid_nxt, err_nxt;

  logic [2:0] match_idx;
  logic [5:0] match;
  logic [5:0] final_mask;
  logic [2:0] sel_upc;

  // A start-of-frame digit is always DU0, wherever the FSM currently is.
  assign match_idx = seg_sof ? 3'd0 : idx;

  seg_pattern_match u_match (
    .seg_in (seg_in),
    .idx    (match_idx),
    .match  (match)
  );

  assign final_mask = mask & match;

  // Encoder for the surviving candidate; only meaningful when one-hot.
  always_comb begin
    sel_upc = 3'b000;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (final_mask[i]) begin
        sel_upc = ITEM_UPC[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    mask_nxt  = mask;
    upc_nxt   = upc_out;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;

    if (seg_valid && seg_sof) begin
      // New frame; in COLLECT this silently abandons the old one.
      mask_nxt  = match;
      idx_nxt   = 3'd1;
      state_nxt = COLLECT;
    end else if (seg_valid && (state == COLLECT)) begin
      if (idx == 3'd5) begin
        state_nxt = IDLE;
        idx_nxt   = 3'd0;
        mask_nxt  = '0;
        // Zero or multiple survivors are both reported as errors.
        if ($onehot(final_mask)) begin
          valid_nxt = 1'b1;
          upc_nxt   = sel_upc;
        end else begin
          err_nxt   = 1'b1;
        end
      end else begin
        mask_nxt = final_mask;
        idx_nxt  = idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 3'd0;
      mask      <= '0;
      upc_out   <= 3'b000;
      upc_valid <= 1'b0;
      upc_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      mask      <= mask_nxt;
      upc_out   <= upc_nxt;
      upc_valid <= valid_nxt;
      upc_err   <= err_nxt;
    end
  end

  assign frame_active = (state == COLLECT);

endmodule

// File: tb/tb_display_upc_decoder.sv
// Directed self-checking bench for display_upc_decoder.
module tb_display_upc_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg_in = 7'h7f;
  logic       seg_valid = 1'b0;
  logic       seg_sof = 1'b0;
  logic       frame_active;
  logic [2:0] upc_out;
  logic       upc_valid;
  logic       upc_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  display_upc_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .seg_in       (seg_in),
    .seg_valid    (seg_valid),
    .seg_sof      (seg_sof),
    .frame_active (frame_active),
    .upc_out      (upc_out),
    .upc_valid    (upc_valid),
    .upc_err      (upc_err)
  );

  // Hand-copied frames. Row 6 is PHONE with DU5 replaced by an E.
  localparam int COFFEE = 0, HUBCAP = 1, CANDLE = 2, POPCD = 3, PHONE = 4, BEDPAN = 5, PHONE_BAD = 6;
  localparam logic [6:0] PAT [7][6] = '{
    '{7'b1000110, 7'b1000000, 7'b0001110, 7'b0001110, 7'b0000110, 7'b0000110},
    '{7'b0001001, 7'b1000001, 7'b0000011, 7'b1000110, 7'b0001000, 7'b0001100},
    '{7'b1000110, 7'b0001000, 7'b1001000, 7'b0100001, 7'b1000111, 7'b0000110},
    '{7'b0001100, 7'b1000000, 7'b0001100, 7'b1111111, 7'b1000110, 7'b0100001},
    '{7'b0001100, 7'b0001001, 7'b1000000, 7'b1001000, 7'b0000110, 7'b1111111},
    '{7'b0000011, 7'b0000110, 7'b0100001, 7'b0001100, 7'b0001000, 7'b1001000},
    '{7'b0001100, 7'b0001001, 7'b1000000, 7'b1001000, 7'b0000110, 7'b0000110}
  };

  // Inputs change 1 time unit after an edge; outputs are observed there too.
  task automatic step(input logic v, input logic s, input logic [6:0] seg);
    seg_valid = v;
    seg_sof   = s;
    seg_in    = seg;
    @(posedge clk);
    #1;
  endtask

  task automatic digit(input int item, input int d);
    step(1'b1, (d == 0), PAT[item][d]);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 7'h7f);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    idle();
    idle();
    chk("rst_active", frame_active, 0);
    chk("rst_upc", upc_out, 0);
    chk("rst_valid", upc_valid, 0);
    chk("rst_err", upc_err, 0);
    reset = 1'b0;
    idle();

    // COFFEE back-to-back: active after DU0..DU4, pulse right after DU5
    for (int d = 0; d < 6; d++) begin
      digit(COFFEE, d);
      if (d < 5) begin
        chk($sformatf("coffee_active_d%0d", d), frame_active, 1);
        chk($sformatf("coffee_nopulse_d%0d", d), upc_valid, 0);
      end
    end
    chk("coffee_valid", upc_valid, 1);
    chk("coffee_err", upc_err, 0);
    chk("coffee_upc", upc_out, 3'b000);
    chk("coffee_inactive", frame_active, 0);
    idle();
    chk("coffee_pulse_1cyc", upc_valid, 0);

    // bEdPAN with two idle cycles after every digit
    for (int d = 0; d < 6; d++) begin
      digit(BEDPAN, d);
      chk($sformatf("bedpan_v_d%0d", d), upc_valid, (d == 5));
      idle();
      chk($sformatf("bedpan_gap1_d%0d", d), upc_valid, 0);
      if (d < 5) chk($sformatf("bedpan_hold_d%0d", d), frame_active, 1);
      idle();
    end
    chk("bedpan_upc", upc_out, 3'b110);

    // PHONE with wrong DU5 -> error, upc_out held
    for (int d = 0; d < 6; d++) digit(PHONE_BAD, d);
    chk("phone_bad_err", upc_err, 1);
    chk("phone_bad_valid", upc_valid, 0);
    chk("phone_bad_upc", upc_out, 3'b110);
    idle();
    chk("phone_bad_err_1cyc", upc_err, 0);

    // HUbCAP aborted after 3 digits by a CANdLE start
    for (int d = 0; d < 3; d++) digit(HUBCAP, d);
    for (int d = 0; d < 6; d++) begin
      digit(CANDLE, d);
      if (d < 5) chk($sformatf("abort_quiet_d%0d", d), upc_valid | upc_err, 0);
    end
    chk("candle_valid", upc_valid, 1);
    chk("candle_upc", upc_out, 3'b011);
    idle();

    // Stray digits without sof while idle
    for (int d = 1; d < 4; d++) begin
      step(1'b1, 1'b0, PAT[COFFEE][d]);
      chk($sformatf("stray_active_%0d", d), frame_active, 0);
      chk($sformatf("stray_pulse_%0d", d), upc_valid | upc_err, 0);
    end

    // Reset in the middle of POP Cd
    for (int d = 0; d < 3; d++) digit(POPCD, d);
    chk("popcd_mid_active", frame_active, 1);
    reset = 1'b1;
    step(1'b1, 1'b0, PAT[POPCD][3]);
    reset = 1'b0;
    chk("midrst_active", frame_active, 0);
    chk("midrst_upc", upc_out, 0);
    chk("midrst_pulse", upc_valid | upc_err, 0);
    // Remaining POP Cd digits must not complete a frame
    digit(POPCD, 4);
    digit(POPCD, 5);
    chk("midrst_no_tail", upc_valid | upc_err, 0);
    for (int d = 0; d < 6; d++) digit(POPCD, d);
    chk("popcd_valid", upc_valid, 1);
    chk("popcd_upc", upc_out, 3'b100);
    idle();

    // POP Cd then CANdLE, 12 consecutive valid cycles
    for (int d = 0; d < 6; d++) digit(POPCD, d);
    chk("b2b_first_valid", upc_valid, 1);
    chk("b2b_first_upc", upc_out, 3'b100);
    chk("b2b_gap_inactive", frame_active, 0);
    for (int d = 0; d < 6; d++) begin
      digit(CANDLE, d);
      if (d == 0) begin
        chk("b2b_second_start_active", frame_active, 1);
        chk("b2b_first_pulse_end", upc_valid, 0);
        chk("b2b_upc_held", upc_out, 3'b100);
      end
    end
    chk("b2b_second_valid", upc_valid, 1);
    chk("b2b_second_upc", upc_out, 3'b011);
    idle();
    chk("b2b_end_valid", upc_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
